// File: rtl/joy_dir_arbiter.sv
// joy_dir_arbiter: per-player direction conditioner.
// Each player channel debounces its four direction bits, then applies one of
// four arbitration modes (pass, last-pressed-wins, first-pressed-holds,
// opposite-cancel). Player channels share nothing except the clock, the reset
// and the debounce tick.

module joy_dir_player #(
  parameter int DB_CNT = 0,
  parameter int DB_W   = 4
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       ce_db,
  input  logic [3:0] i_dir,
  input  logic [1:0] i_mode,
  output logic [3:0] o_dir,
  output logic       o_chg
);
  typedef enum logic [1:0] {M_PASS = 2'd0, M_LAST = 2'd1, M_FIRST = 2'd2, M_CANCEL = 2'd3} mode_e;

  localparam logic [DB_W-1:0] LP_DB = DB_W'(DB_CNT);

  logic [3:0]           r_db, r_prev, r_mask, r_sel, r_out;
  logic [1:0]           r_mode_q;
  logic                 r_chg;
  logic [3:0][DB_W-1:0] r_cnt;

  mode_e      w_mode;
  logic       w_mchg;
  logic [3:0] w_new, w_mask_cur, w_sel_cur, w_mask_nxt, w_sel_nxt, w_out_nxt;

  // Highest-index set bit as a one-hot nibble (up > down > left > right); 0 if none.
  function automatic logic [3:0] f_hi(input logic [3:0] x);
    if (x[3])      return 4'b1000;
    else if (x[2]) return 4'b0100;
    else if (x[1]) return 4'b0010;
    else if (x[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  // Per-bit debounce: a raw level must differ from db for DB_CNT ticks to be taken.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_db  <= '0;
      r_cnt <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (DB_CNT == 0) begin
          r_db[b]  <= i_dir[b];
          r_cnt[b] <= '0;
        end else if (i_dir[b] == r_db[b]) begin
          r_cnt[b] <= '0;
        end else if (ce_db) begin
          if (r_cnt[b] + DB_W'(1) == LP_DB) begin
            r_db[b]  <= i_dir[b];
            r_cnt[b] <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + DB_W'(1);
          end
        end
      end
    end
  end

  // A mode switch computes this cycle from cleared mask/sel, in the new mode.
  assign w_mode     = mode_e'(i_mode);
  assign w_mchg     = (i_mode != r_mode_q);
  assign w_mask_cur = w_mchg ? 4'b1111 : r_mask;
  assign w_sel_cur  = w_mchg ? 4'b0000 : r_sel;
  assign w_new      = r_db & ~r_prev;

  // Arbitration: next mask/sel and the next output nibble.
  always_comb begin
    w_mask_nxt = w_mask_cur;
    if (w_new != 4'b0000) w_mask_nxt = f_hi(w_new);
    // Masked bit gone (or nothing held): reopen so every held bit passes.
    if (r_db == 4'b0000 || (r_db & w_mask_nxt) == 4'b0000) w_mask_nxt = 4'b1111;

    // sel is a one-hot nibble, 0 = none; reselect when the held bit drops.
    w_sel_nxt = w_sel_cur;
    if ((r_db & w_sel_cur) == 4'b0000) w_sel_nxt = f_hi(r_db);

    w_out_nxt = r_db;
    case (w_mode)
      M_PASS:  w_out_nxt = r_db;
      M_LAST:  w_out_nxt = r_db & w_mask_nxt;
      M_FIRST: w_out_nxt = w_sel_nxt;
      default: begin
        if (r_db[3] && r_db[2]) w_out_nxt[3:2] = 2'b00;
        if (r_db[1] && r_db[0]) w_out_nxt[1:0] = 2'b00;
      end
    endcase
  end

  // Arbitration state, registered output and change pulse.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prev   <= '0;
      r_mask   <= 4'b1111;
      r_sel    <= '0;
      r_mode_q <= '0;
      r_out    <= '0;
      r_chg    <= 1'b0;
    end else begin
      r_prev   <= r_db;
      r_mask   <= (w_mode == M_LAST)  ? w_mask_nxt : 4'b1111;
      r_sel    <= (w_mode == M_FIRST) ? w_sel_nxt  : 4'b0000;
      r_mode_q <= i_mode;
      r_out    <= w_out_nxt;
      r_chg    <= (w_out_nxt != r_out);
    end
  end

  assign o_dir = r_out;
  assign o_chg = r_chg;
endmodule

module joy_dir_arbiter #(
  parameter int NPLAYERS = 2,
  parameter int DB_CNT   = 0,
  parameter int DB_W     = 4
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  input  logic                  ce_db,
  input  logic [4*NPLAYERS-1:0] indir,
  input  logic [2*NPLAYERS-1:0] mode,
  output logic [4*NPLAYERS-1:0] outdir,
  output logic [NPLAYERS-1:0]   chg
);
  // One independent channel per player.
  for (genvar p = 0; p < NPLAYERS; p++) begin : g_pl
    joy_dir_player #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_pl (
      .clk    (clk),
      .RESET_N(RESET_N),
      .ce_db  (ce_db),
      .i_dir  (indir[4*p +: 4]),
      .i_mode (mode[2*p +: 2]),
      .o_dir  (outdir[4*p +: 4]),
      .o_chg  (chg[p])
    );
  end
endmodule

// File: doc/joy_dir_arbiter.md
# joy_dir_arbiter

Multi-player directional-input conditioner for arcade cores. It sits between the merged joystick/keyboard direction sources and the game input ports. Per player it debounces each direction bit, then applies a selectable arbitration mode: pass-through, last-pressed-wins, first-pressed-holds, or opposite-cancel. It replaces the single-player, fixed-mode last-pressed-wins filter with a parametrised, per-player-mode block.

## Interface
- NPLAYERS, 2, number of independent 4-direction channels (1..4)
- DB_CNT, 0, debounce length in ce_db ticks; 0 disables debounce (1-cycle register only)
- DB_W, 4, debounce counter width; DB_CNT < 2^DB_W required

- clk  in  1  system clock (clk_sys domain)
- RESET_N  in  1  reset, asynchronous assert, active-low
- ce_db  in  1  debounce tick enable (e.g. 1 kHz strobe in clk domain)
- indir  in  4*NPLAYERS  raw directions; player p at [4p+3:4p], bit order {up,down,left,right}
- mode  in  2*NPLAYERS  per-player mode at [2p+1:2p]: 0 PASS, 1 LAST, 2 FIRST, 3 CANCEL
- outdir  out  4*NPLAYERS  conditioned directions, same bit layout
- chg  out  NPLAYERS  1-cycle pulse when the player's outdir nibble changed on this clock

## Operation
- Reset (RESET_N low, async): outdir=0, chg=0, debounced db=0, prev=0, counters=0, mask=4'b1111, sel=none, mode_q=0.
- Stage 1, debounce, per bit:
  - DB_CNT=0: db <= indir every clk.
  - Else: if raw==db, cnt<=0. If raw!=db and ce_db, cnt<=cnt+1. When the increment would reach DB_CNT, db<=raw and cnt<=0.
  - A raw glitch shorter than DB_CNT ticks never reaches db.
- Stage 2, arbitration, per player, on db nibble d. prev holds last cycle's d. new = d & ~prev. The nibble is registered into outdir.
- PASS: outdir = d.
- LAST:
  - On any new bit, mask = one-hot of the highest-index new bit (up > down > left > right).
  - If (d & mask_next)==0 or d==0, mask = 1111.
  - outdir = d & mask_next.
- FIRST:
  - If sel==none and d!=0, sel = highest-index set bit of d.
  - If sel valid and d[sel]==0, sel = highest set bit of d, or none if d==0. This evaluates in the same cycle.
  - outdir = one-hot(sel) or 0. New presses are ignored while d[sel] is held.
- CANCEL:
  - outdir = d with up/down both cleared if both set, and left/right both cleared if both set.
  - Otherwise unchanged.
- Mode change: when mode[p] != mode_q[p], set mask=1111, sel=none, mode_q<=mode. The output for that cycle is computed in the new mode from the cleared state.
- chg[p] = (next outdir nibble != current outdir nibble), registered alongside outdir.
- Players are fully independent; no cross-player state.

## Timing
- DB_CNT=0: indir change at edge n gives db at n+1 and outdir/chg at n+2. Fixed 2-clock latency.
- DB_CNT=k: a stable change is accepted on the k-th ce_db tick after the change, then outdir follows 1 clock later.
- Simultaneous new presses in LAST: highest index wins, deterministically.
- Release of the masked bit while others are held (LAST): next cycle mask=1111 and all held bits pass. This matches the legacy filter.
- chg is high for exactly one clock per outdir change, never two in a row for a single transition.
- Reset mid-operation clears outputs immediately (async). The first valid outdir appears 2 clocks after RESET_N rises.

## Test plan
- PASS, DB_CNT=0: indir p0=4'b1010 at cycle 0 -> outdir[3:0]=1010 and chg[0]=1 at cycle 2; chg[0]=0 at cycle 3.
- LAST: hold right (0001), then add up (1001) -> outdir 0001 then 1000. Release up -> 0001 two clocks later.
- LAST, simultaneous new press 0110 from 0000 -> outdir 0100 (down wins).
- FIRST: press left (0010), add up (1010) -> outdir stays 0010. Release left -> 1000 two clocks later.
- CANCEL: indir 1101 -> outdir 0001. Indir 1111 -> 0000.
- Debounce DB_CNT=3, ce_db every 4 clk: 2-tick pulse on p1 up -> outdir unchanged. Pulse held for 3 ticks -> outdir[7]=1 one clock after the third tick.
- Async reset asserted mid-hold: outdir=0 and chg=0 immediately, without waiting for a clk edge.
